// File: rtl/irq_fifo.sv
// Dual notification queue: one for completed data messages, one for interrupt packets.
// The receive unit pushes SPM addresses into them; the processor pops one entry per read.
module irq_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [13:0]   irq_fifo_data,
    input  logic          irq_fifo_data_valid,
    input  logic          irq_fifo_irq_valid,
    input  logic          rd_en,
    input  logic          rd_sel,
    input  logic          ovf_clr,
    output logic [13:0]   rd_data,
    output logic          rd_valid,
    output logic          rd_empty,
    output logic          data_irq,
    output logic          irq_irq,
    output logic [CW-1:0] data_count,
    output logic [CW-1:0] irq_count,
    output logic          data_ovf,
    output logic          irq_ovf
);

    // Index 0 is the data queue, index 1 the irq queue (matches rd_sel encoding).
    logic [13:0]   mem  [2][DEPTH];
    logic [AW-1:0] wptr [2];
    logic [AW-1:0] rptr [2];
    logic [CW-1:0] cnt  [2];
    logic          ovf  [2];
    logic          push [2];
    logic          pop  [2];
    logic          acc  [2];

    // A full queue still accepts a push when the same cycle pops it.
    always_comb begin
        push[0] = irq_fifo_data_valid;
        push[1] = irq_fifo_irq_valid;
        for (int q = 0; q < 2; q++) begin
            pop[q] = rd_en && (rd_sel == 1'(q)) && (cnt[q] != '0);
            acc[q] = push[q] && ((cnt[q] != CW'(DEPTH)) || pop[q]);
        end
    end

    always_ff @(posedge clk) begin
        for (int q = 0; q < 2; q++) begin
            if (acc[q]) begin
                mem[q][wptr[q]] <= irq_fifo_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int q = 0; q < 2; q++) begin
                wptr[q] <= '0;
                rptr[q] <= '0;
                cnt[q]  <= '0;
                ovf[q]  <= 1'b0;
            end
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_empty <= 1'b0;
        end else begin
            for (int q = 0; q < 2; q++) begin
                if (acc[q]) begin
                    wptr[q] <= wptr[q] + 1'b1;
                end
                if (pop[q]) begin
                    rptr[q] <= rptr[q] + 1'b1;
                end
                cnt[q] <= cnt[q] + CW'(acc[q]) - CW'(pop[q]);
                if (push[q] && !acc[q]) begin
                    ovf[q] <= 1'b1;
                end else if (ovf_clr) begin
                    ovf[q] <= 1'b0;
                end
            end
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_empty <= !pop[rd_sel];
                rd_data  <= pop[rd_sel] ? mem[rd_sel][rptr[rd_sel]] : '0;
            end
        end
    end

    assign data_count = cnt[0];
    assign irq_count  = cnt[1];
    assign data_irq   = (cnt[0] != '0);
    assign irq_irq    = (cnt[1] != '0);
    assign data_ovf   = ovf[0];
    assign irq_ovf    = ovf[1];

endmodule

// File: doc/irq_fifo.md
IRQ_FIFO -- requirements
Module: irq_fifo

Interface
REQ-001 Parameter DEPTH, default 16, entries per queue; SHALL be a power of two, 2..256; CW = log2(DEPTH)+1.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset; asserting (0) SHALL clear all state immediately, independent of clk.
REQ-004 irq_fifo_data  in  14  SPM address carried by the receive unit's notification.
REQ-005 irq_fifo_data_valid  in  1  push irq_fifo_data into the data queue (last data packet of a message received).
REQ-006 irq_fifo_irq_valid  in  1  push irq_fifo_data into the irq queue (interrupt packet received).
REQ-007 rd_en  in  1  pop request from the processor side.
REQ-008 rd_sel  in  1  queue for rd_en: 0 = data queue, 1 = irq queue.
REQ-009 ovf_clr  in  1  clears both overflow flags.
REQ-010 rd_data  out  14  popped entry, registered.
REQ-011 rd_valid  out  1  one-cycle pulse: rd_data/rd_empty valid.
REQ-012 rd_empty  out  1  qualifies rd_valid: selected queue was empty.
REQ-013 data_irq  out  1  data queue non-empty.
REQ-014 irq_irq  out  1  irq queue non-empty.
REQ-015 data_count, irq_count  out  CW  occupancy of each queue, 0..DEPTH.
REQ-016 data_ovf, irq_ovf  out  1  sticky: a push was dropped on a full queue.

Function
REQ-017 Two independent circular queues, each with write pointer, read pointer (log2(DEPTH) bits, wrap DEPTH-1 -> 0) and CW-bit count; storage SHALL be DEPTH x 14 bits each.
REQ-018 Push with count < DEPTH SHALL store the entry at the write pointer and advance it; count increments next cycle unless a pop of the same queue occurs in the same cycle.
REQ-019 Push with count = DEPTH and no same-cycle pop SHALL be dropped, storage and pointers unchanged, and the queue's overflow flag set at the next edge.
REQ-020 Push on full with a same-cycle pop of the same queue SHALL be accepted; count stays DEPTH, no overflow.
REQ-021 irq_fifo_data_valid and irq_fifo_irq_valid both high SHALL push the same irq_fifo_data into both queues in that cycle.
REQ-022 rd_en with count > 0 SHALL register the entry at the read pointer into rd_data, advance the pointer, and assert rd_valid=1, rd_empty=0 in the next cycle (latency 1).
REQ-023 rd_en with count = 0 SHALL give rd_valid=1, rd_empty=1, rd_data=0 next cycle with no state change; a same-cycle push to that queue SHALL NOT bypass to the read, but SHALL be stored.
REQ-024 Entry pushed in cycle N SHALL be poppable by rd_en in cycle N+1.
REQ-025 rd_valid SHALL be 0 in every cycle not following an rd_en; rd_data SHALL hold its last value when rd_valid=0.
REQ-026 data_irq/irq_irq SHALL equal (count != 0), registered with the counts.
REQ-027 ovf_clr SHALL clear both flags next cycle; a concurrent overflowing push SHALL win (flag set).
REQ-028 Back-to-back rd_en every cycle SHALL be sustained with one pop per cycle.

Reset
REQ-029 reset=0 SHALL clear pointers, counts, overflow flags, rd_data, rd_valid and rd_empty to 0, hence data_irq=irq_irq=0; storage contents need not be cleared.
REQ-030 Pushes and pops in flight during reset SHALL be discarded; the first push after release SHALL land at entry 0.

Verification
REQ-031 Push 0x0010, 0x0011, 0x0012 to data queue; rd_sel=0 rd_en x3 -> rd_data 0x0010, 0x0011, 0x0012 on consecutive cycles, data_count 3 -> 0, data_irq falls after last pop.
REQ-032 DEPTH=16: 17 irq pushes 0x0001..0x0011 -> irq_count=16, irq_ovf=1, pops return 0x0001..0x0010; ovf_clr -> irq_ovf=0.
REQ-033 Both valids high with data 0x2ABC -> data_count=irq_count=1; pop each -> 0x2ABC twice.
REQ-034 Empty irq queue, rd_sel=1 rd_en with simultaneous irq push 0x0005 -> rd_valid=1, rd_empty=1, rd_data=0; next pop returns 0x0005.
REQ-035 Fill data queue to 16, then push+pop same cycle -> count stays 16, data_ovf=0; 20 push/pop rounds exercise pointer wrap with FIFO order preserved.
REQ-036 Assert reset asynchronously mid-stream with count 5 -> counts, flags, rd_valid 0 before next clk edge; post-release push/pop returns the new entry.
